// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address, buffers fetched
// instructions in a small prefetch queue and traps illegal fetch addresses.
module instr_fetch_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                INSTR_W   = 16,
  parameter int                MEM_BYTES = 1024,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_instr,
  output logic [INSTR_W-1:0]       dec_instr,
  output logic [ADDR_W-1:0]        dec_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     fault,
  output logic [ADDR_W-1:0]        fault_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  fault_pc_q, fault_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];
  logic               push, pop, flush, pop_ok, full;
  logic               fetch_legal, redirect_legal;

  // The +3 is done one bit wider so an address near the top of the space cannot wrap.
  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] last;
    last = {1'b0, a} + (ADDR_W+1)'(3);
    return (a[1:0] == 2'b00) && (last < (ADDR_W+1)'(MEM_BYTES));
  endfunction

  assign fetch_legal    = is_legal(fetch_pc_q);
  assign redirect_legal = is_legal(redirect_pc);
  assign full           = (count_q == CNT_W'(DEPTH));
  assign pop_ok         = (count_q != '0) && dec_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_pc_d = fault_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (start)    state_d    = RUN;
      end
      RUN: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d    = FAULT;
            fault_pc_d = redirect_pc;
          end
        end else begin
          pop = pop_ok;
          if (!fetch_legal) begin
            state_d    = FAULT;
            fault_pc_d = fetch_pc_q;
          end else if (!full || pop_ok) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          end
        end
      end
      FAULT: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          if (redirect_legal) state_d    = RUN;
          else                fault_pc_d = redirect_pc;
        end else begin
          pop = pop_ok;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect squashes everything in flight, including a same-cycle pop.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      fault_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_pc_q <= fault_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: stale slots are never visible through the masked outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr_q] <= imem_instr;
      q_pc[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign dec_valid = (count_q != '0);
  assign dec_instr = dec_valid ? q_instr[rd_ptr_q] : '0;
  assign dec_pc    = dec_valid ? q_pc[rd_ptr_q]    : '0;
  assign fault     = (state_q == FAULT);
  assign fault_pc  = fault_pc_q;
  assign q_count   = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int MEM_BYTES = 1024;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        dec_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr, imem_instr, dec_instr, dec_pc, fault_pc;
  logic        dec_valid, fault;
  logic [2:0]  q_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;
  typedef enum {M_IDLE, M_RUN, M_FAULT} mode_e;

  entry_t      mq[$];
  mode_e       mMode;
  logic [15:0] mPc, mFaultPc;

  always #5 clk = ~clk;

  // ROM contents: word i holds i + 0x100.
  assign imem_instr = 16'((imem_addr >> 2) + 16'h100);

  instr_fetch_ctrl #(
    .ADDR_W(16), .INSTR_W(16), .MEM_BYTES(MEM_BYTES), .DEPTH(DEPTH), .RESET_PC(16'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fault(fault), .fault_pc(fault_pc), .q_count(q_count)
  );

  function automatic bit legalAddr(input logic [15:0] a);
    return (a % 4 == 0) && (int'(a) + 3 < MEM_BYTES);
  endfunction

  function automatic logic [15:0] romWord(input logic [15:0] a);
    return 16'(a / 4 + 16'h100);
  endfunction

  task automatic modelReset();
    mq.delete();
    mMode    = M_IDLE;
    mPc      = 16'h0;
    mFaultPc = 16'h0;
  endtask

  // One clock edge of the reference behaviour, using the inputs presented before it.
  task automatic modelStep();
    bit popNow;
    popNow = (mq.size() > 0) && dec_ready;
    case (mMode)
      M_IDLE: begin
        if (redirect) mPc = redirect_pc;
        if (start) mMode = M_RUN;
      end
      M_RUN: begin
        if (redirect) begin
          mq.delete();
          mPc = redirect_pc;
          if (redirect_pc % 4 != 0) begin
            mMode    = M_FAULT;
            mFaultPc = redirect_pc;
          end
        end else if (!legalAddr(mPc)) begin
          mMode    = M_FAULT;
          mFaultPc = mPc;
          if (popNow) void'(mq.pop_front());
        end else begin
          bit room;
          room = (mq.size() < DEPTH) || popNow;
          if (popNow) void'(mq.pop_front());
          if (room) begin
            mq.push_back('{instr: romWord(mPc), pc: mPc});
            mPc = mPc + 16'd4;
          end
        end
      end
      default: begin
        if (redirect) begin
          mq.delete();
          mPc = redirect_pc;
          if (legalAddr(redirect_pc)) mMode = M_RUN;
          else mFaultPc = redirect_pc;
        end else if (popNow) begin
          void'(mq.pop_front());
        end
      end
    endcase
  endtask

  task automatic checkField(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit v;
    v = (mq.size() > 0);
    checkField("dec_valid", 16'(dec_valid), 16'(v));
    checkField("dec_instr", dec_instr, v ? mq[0].instr : 16'h0);
    checkField("dec_pc", dec_pc, v ? mq[0].pc : 16'h0);
    checkField("imem_addr", imem_addr, mPc);
    checkField("fault", 16'(fault), 16'(mMode == M_FAULT));
    checkField("fault_pc", fault_pc, mFaultPc);
    checkField("q_count", 16'(q_count), 16'(mq.size()));
  endtask

  task automatic applyStimulus(input logic s, input logic rd, input logic r, input logic [15:0] rpc);
    start       = s;
    dec_ready   = rd;
    redirect    = r;
    redirect_pc = rpc;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic asyncReset();
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    start = 1'b0; redirect = 1'b0; dec_ready = 1'b0;
    @(negedge clk);
    checkOutput();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rpc;
    modelReset();
    $display("[TB] reset check");
    #1 checkOutput();
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] streaming");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] async reset mid-stream");
    asyncReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] backpressure");
    asyncReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] redirect with occupied queue");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h40);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] end of ROM");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h3F8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h22);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h3FE);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);

    $display("[TB] random traffic");
    asyncReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h3E0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 16'($urandom_range(0, 255) * 4);
        1:       rpc = 16'($urandom_range(0, 1023));
        2:       rpc = 16'(16'h3E0 + $urandom_range(0, 12) * 4);
        default: rpc = 16'($urandom);
      endcase
      if (i == 300) asyncReset();
      applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0), rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
